// File: rtl/cpu_state_dump.sv
// Debug dump unit: on request, streams a cycle-stamp header, every general
// register, then the first data-memory words as tagged valid/ready beats.
module cpu_state_dump #(
    parameter int NUM_REGS = 32,
    parameter int NUM_MEM  = 8,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       cycle_i,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [4:0]        mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic [DATA_W-1:0] tdata_o,
    output logic [7:0]        ttag_o,
    output logic              tlast_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_REG,
        S_MEM,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);
    localparam logic [4:0] LAST_MEM = 5'(NUM_MEM - 1);

    state_t      state;
    logic [4:0]  idx;
    logic [31:0] cycle_q;
    logic        slot_free;

    // The single output slot may be refilled when empty or being drained this cycle.
    assign slot_free = !tvalid_o || tready_i;

    // NOTE: reset is synchronous, so it lives inside the clocked block and all
    // state updates use non-blocking assignments.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            idx        <= '0;
            cycle_q    <= '0;
            reg_addr_o <= '0;
            mem_addr_o <= '0;
            tvalid_o   <= 1'b0;
            tdata_o    <= '0;
            ttag_o     <= '0;
            tlast_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cycle_q <= cycle_i;
                        busy_o  <= 1'b1;
                        idx     <= '0;
                        state   <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (slot_free) begin
                        tvalid_o   <= 1'b1;
                        tdata_o    <= DATA_W'(cycle_q);
                        ttag_o     <= 8'hFF;
                        tlast_o    <= 1'b0;
                        idx        <= '0;
                        reg_addr_o <= '0;
                        state      <= S_REG;
                    end
                end

                S_REG: begin
                    if (slot_free) begin
                        tvalid_o <= 1'b1;
                        tdata_o  <= reg_data_i;
                        ttag_o   <= 8'(idx);
                        tlast_o  <= 1'b0;
                        if (idx == LAST_REG) begin
                            idx        <= '0;
                            reg_addr_o <= '0;
                            mem_addr_o <= '0;
                            state      <= S_MEM;
                        end else begin
                            idx        <= idx + 5'd1;
                            reg_addr_o <= idx + 5'd1;
                        end
                    end
                end

                S_MEM: begin
                    if (slot_free) begin
                        // A free slot while tlast_o is set means the final beat was just taken.
                        if (tlast_o) begin
                            tvalid_o   <= 1'b0;
                            tlast_o    <= 1'b0;
                            done_o     <= 1'b1;
                            idx        <= '0;
                            mem_addr_o <= '0;
                            state      <= S_DONE;
                        end else begin
                            tvalid_o <= 1'b1;
                            tdata_o  <= mem_data_i;
                            ttag_o   <= 8'h20 + 8'(idx);
                            tlast_o  <= (idx == LAST_MEM);
                            if (idx != LAST_MEM) begin
                                idx        <= idx + 5'd1;
                                mem_addr_o <= idx + 5'd1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
